c1541_track_ctrl: RTL and testbench

Sequences the 1541 track buffer against the SD image. Watches the head track number, waits for the stepper to settle, writes back the current track if the drive modified it, then loads the new track sector by sector. It sits between the drive logic, the GCR track-buffer block and the SD host, and drives the `busy` that stalls GCR bit generation. Image LBAs are in 256-byte D64 sector units.

---
 rtl/c1541_track_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_c1541_track_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_track_ctrl.sv
// c1541_track_ctrl: sequences the 1541 track buffer against the D64 image on SD.
// Latency: SETTLE_CYC cycles of stable track, then one SD handshake per sector; all outputs registered.
// Backpressure: each block waits on sd_ack (rise then fall); busy stalls the GCR block while the buffer is invalid.
// Ports:
//   clk, reset_n           - clock, synchronous active-low reset
//   track[5:0]             - head track, 1-based (1..40 valid)
//   img_mounted            - image present (level)
//   img_readonly           - suppresses write-back (level)
//   buf_we                 - GCR write strobe into the track buffer (marks it dirty)
//   flush                  - request write-back of a dirty buffer without a track change
//   sd_ack                 - SD host acknowledge, high for one block transfer
//   busy                   - track buffer not valid, GCR must halt
//   sd_rd / sd_wr          - block read / write request
//   sd_lba[31:0]           - D64 sector index of the requested block
//   sd_blk[4:0]            - sector within track (SD-side buffer address high bits)
module c1541_track_ctrl #(
  parameter int unsigned SETTLE_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        buf_we,
  input  logic        flush,
  input  logic        sd_ack,
  output logic        busy,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_lba,
  output logic [4:0]  sd_blk
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_FLUSH, S_LOAD, S_READY} state_t;
  // Per-block handshake phase: SETUP has address stable and request low,
  // REQ holds the request until ack, WAIT waits for ack to fall.
  typedef enum logic [1:0] {PH_SETUP, PH_REQ, PH_WAIT} phase_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  function automatic logic [31:0] trk_base(input logic [5:0] t);
    logic [31:0] tw;
    tw = {26'd0, t};
    if (t <= 6'd17)      return (tw - 32'd1) * 32'd21;
    else if (t <= 6'd24) return 32'd357 + (tw - 32'd18) * 32'd19;
    else if (t <= 6'd30) return 32'd490 + (tw - 32'd25) * 32'd18;
    else                 return 32'd598 + (tw - 32'd31) * 32'd17;
  endfunction

  function automatic logic [4:0] trk_secs(input logic [5:0] t);
    if (t <= 6'd17)      return 5'd21;
    else if (t <= 6'd24) return 5'd19;
    else if (t <= 6'd30) return 5'd18;
    else                 return 5'd17;
  endfunction

  function automatic logic trk_valid(input logic [5:0] t);
    return (t >= 6'd1) && (t <= 6'd40);
  endfunction

  state_t      state_q, state_d;
  phase_t      ph_q, ph_d;
  logic [5:0]  cur_track_q, cur_track_d;
  logic [5:0]  trk_q, trk_d;
  logic        dirty_q, dirty_d;
  logic        from_ready_q, from_ready_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  blk_q, blk_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;

  logic        we_set;
  logic        blk_done;
  logic        last_blk;

  assign we_set   = buf_we && !img_readonly;
  assign last_blk = (blk_q == trk_secs(cur_track_q) - 5'd1);

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    cur_track_d  = cur_track_q;
    trk_d        = track;
    dirty_d      = dirty_q | we_set;
    from_ready_d = from_ready_q;
    cnt_d        = cnt_q;
    blk_d        = blk_q;
    lba_d        = lba_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    busy_d       = busy_q;
    blk_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b1;
        if (!img_mounted) begin
          dirty_d     = 1'b0;
          cur_track_d = 6'd0;
        end else if (trk_valid(track)) begin
          state_d = S_SETTLE;
          cnt_d   = 16'd0;
        end
      end

      S_SETTLE: begin
        if (!img_mounted) begin
          state_d     = S_IDLE;
          dirty_d     = 1'b0;
          cur_track_d = 6'd0;
        end else if (!trk_valid(track)) begin
          // Keep cur_track/dirty: a later settle still writes the old track back.
          state_d = S_IDLE;
        end else if (track != trk_q) begin
          cnt_d = 16'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          blk_d = 5'd0;
          ph_d  = PH_SETUP;
          if (dirty_q && cur_track_q != 6'd0) begin
            // cur_track is left alone during the flush and serves as its target.
            state_d      = S_FLUSH;
            from_ready_d = 1'b0;
            lba_d        = trk_base(cur_track_q);
          end else begin
            state_d     = S_LOAD;
            cur_track_d = track;
            dirty_d     = 1'b0;
            lba_d       = trk_base(track);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_FLUSH, S_LOAD: begin
        case (ph_q)
          PH_SETUP: begin
            // Nothing outstanding yet, so an unmount can abort immediately.
            if (!img_mounted) begin
              state_d     = S_IDLE;
              dirty_d     = 1'b0;
              cur_track_d = 6'd0;
            end else begin
              rd_d = (state_q == S_LOAD);
              wr_d = (state_q == S_FLUSH);
              ph_d = PH_REQ;
            end
          end
          PH_REQ: begin
            if (sd_ack) begin
              rd_d = 1'b0;
              wr_d = 1'b0;
              ph_d = PH_WAIT;
            end
          end
          PH_WAIT: blk_done = !sd_ack;
          default: ph_d = PH_SETUP;
        endcase

        if (blk_done) begin
          ph_d = PH_SETUP;
          if (!img_mounted) begin
            state_d     = S_IDLE;
            dirty_d     = 1'b0;
            cur_track_d = 6'd0;
          end else if (state_q == S_LOAD && track != cur_track_q) begin
            // Re-step mid-load: remaining blocks are abandoned.
            state_d = S_SETTLE;
            cnt_d   = 16'd0;
            dirty_d = 1'b0;
          end else if (!last_blk) begin
            blk_d = blk_q + 5'd1;
            lba_d = trk_base(cur_track_q) + {27'd0, blk_q + 5'd1};
          end else if (state_q == S_LOAD) begin
            state_d = S_READY;
            busy_d  = 1'b0;
          end else begin
            // Flush done; a write landing in this same cycle keeps the buffer dirty.
            dirty_d = we_set;
            if (from_ready_q && track == cur_track_q) begin
              state_d = S_READY;
              busy_d  = 1'b0;
            end else if (from_ready_q || !trk_valid(track)) begin
              // Track moved while flushing: settle on it before loading.
              state_d = trk_valid(track) ? S_SETTLE : S_IDLE;
              cnt_d   = 16'd0;
            end else begin
              state_d     = S_LOAD;
              cur_track_d = track;
              dirty_d     = 1'b0;
              blk_d       = 5'd0;
              lba_d       = trk_base(track);
            end
          end
        end
      end

      S_READY: begin
        if (!img_mounted) begin
          state_d     = S_IDLE;
          busy_d      = 1'b1;
          dirty_d     = 1'b0;
          cur_track_d = 6'd0;
        end else if (track != cur_track_q) begin
          // Track change beats a simultaneous flush; dirty data goes out via SETTLE.
          state_d = S_SETTLE;
          cnt_d   = 16'd0;
          busy_d  = 1'b1;
        end else if (flush && dirty_q) begin
          state_d      = S_FLUSH;
          from_ready_d = 1'b1;
          busy_d       = 1'b1;
          blk_d        = 5'd0;
          lba_d        = trk_base(cur_track_q);
          ph_d         = PH_SETUP;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ph_q         <= PH_SETUP;
      cur_track_q  <= 6'd0;
      trk_q        <= 6'd0;
      dirty_q      <= 1'b0;
      from_ready_q <= 1'b0;
      cnt_q        <= 16'd0;
      blk_q        <= 5'd0;
      lba_q        <= 32'd0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      cur_track_q  <= cur_track_d;
      trk_q        <= trk_d;
      dirty_q      <= dirty_d;
      from_ready_q <= from_ready_d;
      cnt_q        <= cnt_d;
      blk_q        <= blk_d;
      lba_q        <= lba_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign sd_rd  = rd_q;
  assign sd_wr  = wr_q;
  assign sd_lba = lba_q;
  assign sd_blk = blk_q;

endmodule

// File: tb/tb_c1541_track_ctrl.sv
// Directed bench for c1541_track_ctrl with a small SD host model that logs
// every request and acknowledges it a few cycles later.
module tb_c1541_track_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  track;
  logic        img_mounted;
  logic        img_readonly;
  logic        buf_we;
  logic        flush;
  logic        sd_ack;
  logic        busy;
  logic        sd_rd;
  logic        sd_wr;
  logic [31:0] sd_lba;
  logic [4:0]  sd_blk;

  always #5 clk = ~clk;

  c1541_track_ctrl #(.SETTLE_CYC(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .track        (track),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .buf_we       (buf_we),
    .flush        (flush),
    .sd_ack       (sd_ack),
    .busy         (busy),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_lba       (sd_lba),
    .sd_blk       (sd_blk)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic        log_wr  [256];
  logic [31:0] log_lba [256];
  logic [4:0]  log_blk [256];
  int n_log     = 0;
  int tot_log   = 0;
  int req_rises = 0;
  int both_hi   = 0;
  int lba_moved = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SD host: sees a request, acks on the 3rd cycle, holds ack 2 cycles.
  initial begin
    logic [31:0] lba0;
    logic [4:0]  blk0;
    sd_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sd_rd || sd_wr) begin
        if (n_log < 256) begin
          log_wr[n_log]  = sd_wr;
          log_lba[n_log] = sd_lba;
          log_blk[n_log] = sd_blk;
        end
        n_log++;
        tot_log++;
        lba0 = sd_lba;
        blk0 = sd_blk;
        repeat (2) @(posedge clk);
        #1 sd_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (sd_lba !== lba0 || sd_blk !== blk0) lba_moved++;
        sd_ack = 1'b0;
      end
    end
  end

  // Protocol monitor: request rising edges and rd/wr overlap.
  initial begin
    logic req_prev;
    req_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sd_rd && sd_wr) both_hi++;
      if ((sd_rd || sd_wr) && !req_prev) req_rises++;
      req_prev = sd_rd || sd_wr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, (k < 3000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_log(input string tag, input int idx0, input int cnt,
                           input logic is_wr, input int lba_base);
    for (int i = 0; i < cnt; i++) begin
      check($sformatf("%s_op%0d", tag, i),  32'(log_wr[idx0 + i]), 32'(is_wr));
      check($sformatf("%s_lba%0d", tag, i), log_lba[idx0 + i], 32'(lba_base + i));
      check($sformatf("%s_blk%0d", tag, i), 32'(log_blk[idx0 + i]), 32'(i));
    end
  endtask

  task automatic pulse_we();
    buf_we = 1'b1; tick(1); buf_we = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(1); flush = 1'b0;
  endtask

  initial begin
    int k;
    int nl;
    reset_n      = 1'b0;
    track        = 6'd0;
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    buf_we       = 1'b0;
    flush        = 1'b0;
    tick(3);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd",   32'(sd_rd), 32'd0);
    check("rst_wr",   32'(sd_wr), 32'd0);
    check("rst_lba",  sd_lba, 32'd0);
    check("rst_blk",  32'(sd_blk), 32'd0);
    reset_n = 1'b1;
    tick(5);
    check("idle_busy", 32'(busy), 32'd1);
    check("idle_nolog", 32'(n_log), 32'd0);

    // Cold load of track 18.
    img_mounted = 1'b1;
    track = 6'd18;
    tick(1);
    wait_ready("t1_ready");
    check("t1_count", 32'(n_log), 32'd19);
    check_log("t1", 0, 19, 1'b0, 357);

    // Clean step to track 1, then dirty step to track 2.
    n_log = 0;
    track = 6'd1;
    tick(1);
    wait_ready("t2a_ready");
    check("t2a_count", 32'(n_log), 32'd21);
    check_log("t2a", 0, 21, 1'b0, 0);
    n_log = 0;
    pulse_we();
    track = 6'd2;
    tick(1);
    wait_ready("t2_ready");
    check("t2_count", 32'(n_log), 32'd42);
    check_log("t2w", 0, 21, 1'b1, 0);
    check_log("t2r", 21, 21, 1'b0, 21);

    // Read-only: write strobe must not cause write-back.
    img_readonly = 1'b1;
    n_log = 0;
    pulse_we();
    track = 6'd3;
    tick(1);
    wait_ready("t3_ready");
    img_readonly = 1'b0;
    check("t3_count", 32'(n_log), 32'd21);
    check_log("t3", 0, 21, 1'b0, 42);

    // Re-step to 36 once block 3 of track 35 has been requested.
    n_log = 0;
    track = 6'd35;
    k = 0;
    while (n_log < 4 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("t4_blk3_seen", (k < 1000) ? 32'd1 : 32'd0, 32'd1);
    track = 6'd36;
    tick(1);
    wait_ready("t4_ready");
    check("t4_count", 32'(n_log), 32'd21);
    check_log("t4a", 0, 4, 1'b0, 666);
    check_log("t4b", 4, 17, 1'b0, 683);

    // Flush in place on track 25.
    n_log = 0;
    track = 6'd25;
    tick(1);
    wait_ready("t5a_ready");
    check("t5a_count", 32'(n_log), 32'd18);
    n_log = 0;
    pulse_we();
    pulse_flush();
    tick(1);
    wait_ready("t5_ready");
    check("t5_count", 32'(n_log), 32'd18);
    check_log("t5", 0, 18, 1'b1, 490);
    n_log = 0;
    pulse_flush();
    tick(40);
    check("t5_second_flush_idle", 32'(n_log), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);

    // Unmount while the SD host is acknowledging a flush write.
    n_log = 0;
    pulse_we();
    pulse_flush();
    k = 0;
    while (sd_ack !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t6_ack_seen", (k < 200) ? 32'd1 : 32'd0, 32'd1);
    tick(1);
    check("t6_ack_high", 32'(sd_ack), 32'd1);
    check("t6_wr_dropped", 32'(sd_wr), 32'd0);
    img_mounted = 1'b0;
    nl = n_log;
    tick(40);
    check("t6_no_more_req", 32'(n_log), 32'(nl));
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_rd", 32'(sd_rd), 32'd0);
    check("t6_wr", 32'(sd_wr), 32'd0);
    n_log = 0;
    img_mounted = 1'b1;
    tick(1);
    wait_ready("t6_reload_ready");
    check("t6_reload_count", 32'(n_log), 32'd18);
    check_log("t6", 0, 18, 1'b0, 490);

    check("proto_rd_wr_overlap", 32'(both_hi), 32'd0);
    check("proto_addr_stable", 32'(lba_moved), 32'd0);
    check("proto_req_vs_served", 32'(req_rises), 32'(tot_log));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
